// File: rtl/vmp_pkg.sv
// Shared types and helpers for the vector memory master: element sizes,
// FSM states and the size-to-byte-enable mapping.
package vmp_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } vmp_size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } vmp_state_t;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic logic [3:0] size_to_be(input vmp_size_t sz);
        case (sz)
            SZ_BYTE: return BE_BYTE;
            SZ_HALF: return BE_HALF;
            default: return BE_WORD;
        endcase
    endfunction

    // The raw encoding 3 has no size of its own and behaves as a word.
    function automatic vmp_size_t decode_size(input logic [1:0] raw);
        if (raw == 2'd3) begin
            return SZ_WORD;
        end
        return vmp_size_t'(raw);
    endfunction

endpackage

// File: rtl/vmp_addr_gen.sv
// Element address accumulator: loads the base on accept and adds the stride
// once per issued element, wrapping silently at the address width.
module vmp_addr_gen #(
    parameter int ADDR_W = 18,
    parameter int IDX_W  = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] stride,
    output logic [ADDR_W-1:0] address,
    output logic [IDX_W-1:0]  index
);

    logic [ADDR_W-1:0] acc;
    logic [IDX_W-1:0]  idx;

    always_ff @(posedge clock) begin
        if (reset) begin
            acc <= '0;
            idx <= '0;
        end else if (load) begin
            acc <= base;
            idx <= '0;
        end else if (advance) begin
            acc <= acc + stride;
            idx <= idx + IDX_W'(1);
        end
    end

    assign address = acc;
    assign index   = idx;

endmodule

// File: rtl/vec_mem_master.sv
// Vector load/store sequencer on one RAM port: one element per cycle, loads
// gathered into a lane-packed result. Optional macro VMP_SIGN_EXT_EN adds cmd_signed.
module vec_mem_master
    import vmp_pkg::*;
#(
    parameter int LANES  = 8,
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [ADDR_W-1:0]          cmd_base,
    input  logic [ADDR_W-1:0]          cmd_stride,
    input  logic [1:0]                 cmd_size,
    input  logic [$clog2(LANES+1)-1:0] cmd_count,
    input  logic [LANES*DATA_W-1:0]    cmd_wdata,
`ifdef VMP_SIGN_EXT_EN
    input  logic                       cmd_signed,
`endif
    output logic [LANES*DATA_W-1:0]    ld_data,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_W-1:0]          mem_address,
    output logic [DATA_W-1:0]          mem_data_in,
    output logic [3:0]                 mem_byte_enablers,
    output logic                       mem_write_enable,
    input  logic [DATA_W-1:0]          mem_data_out
);

    localparam int CNT_W  = $clog2(LANES + 1);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    vmp_state_t          state;
    vmp_state_t          next_state;
    logic                write_q;
    vmp_size_t           size_q;
    logic [CNT_W-1:0]    count_q;
    logic [LANES*DATA_W-1:0] wdata_q;
    logic                ext_signed;
    logic                accept;
    logic                issuing;
    logic                last_issue;
    logic                last_capture;
    logic [CNT_W-1:0]    clamped_count;
    logic [ADDR_W-1:0]   elem_addr;
    logic [LANE_W-1:0]   issue_lane;
    logic [RD_LAT-1:0]   pipe_valid;
    logic [LANE_W-1:0]   pipe_lane [RD_LAT];
    logic                rd_valid;
    logic [LANE_W-1:0]   rd_lane;

    // Handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both high; cmd_ready is high only in IDLE, so offers made
    // while busy are simply not taken and nothing is queued.
    assign accept        = cmd_valid && cmd_ready;
    assign clamped_count = (cmd_count > CNT_W'(LANES)) ? CNT_W'(LANES) : cmd_count;
    assign issuing       = (state == ISSUE);
    assign last_issue    = issuing && (CNT_W'(issue_lane) == count_q - CNT_W'(1));
    assign rd_valid      = pipe_valid[RD_LAT-1];
    assign rd_lane       = pipe_lane[RD_LAT-1];
    assign last_capture  = (state == DRAIN) && rd_valid &&
                           (CNT_W'(rd_lane) == count_q - CNT_W'(1));

    vmp_addr_gen #(
        .ADDR_W (ADDR_W),
        .IDX_W  (LANE_W)
    ) u_addr_gen (
        .clock   (clock),
        .reset   (reset),
        .load    (accept),
        .advance (issuing),
        .base    (cmd_base),
        .stride  (cmd_stride),
        .address (elem_addr),
        .index   (issue_lane)
    );

    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] d,
                                                 input vmp_size_t sz,
                                                 input logic sgn);
        case (sz)
            SZ_BYTE: return {{(DATA_W-8){sgn & d[7]}}, d[7:0]};
            SZ_HALF: return {{(DATA_W-16){sgn & d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (clamped_count == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (last_issue) begin
                    next_state = write_q ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (last_capture) begin
                    next_state = DONE;
                end
            end
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_comb begin
        mem_address       = '0;
        mem_byte_enablers = '0;
        mem_data_in       = '0;
        mem_write_enable  = 1'b0;
        if (issuing) begin
            mem_address       = elem_addr;
            mem_byte_enablers = size_to_be(size_q);
            if (write_q) begin
                mem_data_in      = wdata_q[issue_lane*DATA_W +: DATA_W];
                mem_write_enable = !reset;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            write_q <= 1'b0;
            size_q  <= SZ_BYTE;
            count_q <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            write_q <= cmd_write;
            size_q  <= decode_size(cmd_size);
            count_q <= clamped_count;
            wdata_q <= cmd_wdata;
        end
    end

`ifdef VMP_SIGN_EXT_EN
    logic signed_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            signed_q <= 1'b0;
        end else if (accept) begin
            signed_q <= cmd_signed;
        end
    end

    assign ext_signed = signed_q;
`else
    assign ext_signed = 1'b0;
`endif

    // Each issued read carries its lane number down a pipe matching the RAM latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            pipe_valid <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_lane[k] <= '0;
            end
        end else begin
            pipe_valid[0] <= issuing && !write_q;
            pipe_lane[0]  <= issue_lane;
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
                pipe_lane[k]  <= pipe_lane[k-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ld_data <= '0;
        end else if (accept && !cmd_write) begin
            ld_data <= '0;
        end else if (rd_valid) begin
            ld_data[rd_lane*DATA_W +: DATA_W] <= extend(mem_data_out, size_q, ext_signed);
        end
    end

endmodule
